fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter addr_width, default 4, meaning memory address width; depth D = 2**addr_width.
REQ-002 SHALL have parameter af_thresh, default (2**addr_width)-2, meaning the fill level at which almost_full asserts.
REQ-003 SHALL have port w_clk  input  1  write-domain clock; all state rises on posedge w_clk.
REQ-004 SHALL have port w_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port w_inc  input  1  write request from producer.
REQ-006 SHALL have port rd_ptr_gray  input  addr_width+1  read pointer (Gray), asynchronous to w_clk.
REQ-007 SHALL have port w_address  output  addr_width  memory write address = low bits of binary write pointer.
REQ-008 SHALL have port w_ptr_gray  output  addr_width+1  registered Gray write pointer for read-domain synchronisation.
REQ-009 SHALL have port full_flag  output  1  registered full; gates memory writes.
REQ-010 SHALL have port almost_full  output  1  registered, level >= af_thresh.
REQ-011 SHALL have port w_level  output  addr_width+1  registered fill level, 0..D.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse, write attempted while full.

Function
REQ-013 SHALL synchronise rd_ptr_gray through two w_clk flops (rq1, rq2); no other logic SHALL use rd_ptr_gray directly.
REQ-014 SHALL hold binary pointer wbin and Gray pointer wgray, both addr_width+1 bits; wgray = wbin ^ (wbin >> 1) at all times.
REQ-015 Write accepted = w_inc && !full_flag, evaluated on the current registered full_flag.
REQ-016 On accepted write, wbin SHALL increment by 1 modulo 2**(addr_width+1); otherwise hold.
REQ-017 w_address SHALL equal wbin[addr_width-1:0]; wraps D-1 -> 0 with wbin MSB toggling.
REQ-018 w_ptr_gray SHALL equal the registered wgray (no combinational path from w_inc).
REQ-019 Next-state values: wbin_nxt, wgray_nxt = gray(wbin_nxt); rbin_s = Gray-to-binary of rq2.
REQ-020 full_flag SHALL register (wgray_nxt == {~rq2[addr_width:addr_width-1], rq2[addr_width-2:0]}).
REQ-021 Full SHALL therefore assert on the same edge as the write that fills the FIFO (zero extra latency).
REQ-022 w_level SHALL register (wbin_nxt - rbin_s) modulo 2**(addr_width+1); never exceeds D.
REQ-023 almost_full SHALL register (wbin_nxt - rbin_s) >= af_thresh.
REQ-024 overflow SHALL register (w_inc && full_flag); high for exactly one cycle per rejected request.
REQ-025 A change on rd_ptr_gray SHALL affect full_flag, almost_full, w_level at the third w_clk edge after it (rq1, rq2, flag).
REQ-026 Simultaneous accepted write and read-pointer advance SHALL yield level unchanged once sync completes; no false full.
REQ-027 Rejected writes SHALL leave wbin, wgray, w_address unchanged.

Reset
REQ-028 w_rst_n low SHALL immediately clear wbin, wgray, rq1, rq2, full_flag, almost_full, overflow, w_level to 0, independent of w_clk.
REQ-029 Reset asserted mid-operation SHALL discard pending state; first write after release SHALL target w_address 0.
REQ-030 Release SHALL be synchronous-safe: first state change only on a posedge w_clk with w_rst_n high.

Verification (addr_width=4, D=16, af_thresh=14)
REQ-031 rd_ptr_gray=0, 16 consecutive w_inc -> w_address 0..15, full_flag=1 at 16th accept edge, w_ptr_gray=5'b11000, w_level=16.
REQ-032 Full, w_inc held 2 more cycles -> pointers unchanged, overflow high 2 cycles, full_flag stays 1.
REQ-033 Full, drive rd_ptr_gray=5'b00001 -> full_flag=0 and w_level=15 exactly 3 edges later; next w_inc writes address 0.
REQ-034 Fill to level 13 then one write -> almost_full=1 on that edge with w_level=14; read pointer advance to 1 -> almost_full=0 after 3 edges.
REQ-035 Run 40 writes with rd_ptr_gray tracking 2 behind -> wbin wraps 31->0, w_ptr_gray one-bit changes only, full_flag never asserts.
REQ-036 Assert w_rst_n low between edges at level 9 -> all outputs 0 immediately; after release, write hits w_address 0, w_level=1.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// ============================================================================
// Module   : fifo_wr_ctrl
// Brief    : Write-side controller of an asynchronous FIFO. It keeps the
//            binary/Gray write pointers and the registered full, almost-full,
//            fill-level and overflow status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_ctrl #(
    parameter int addr_width = 4,
    parameter int af_thresh  = (2**addr_width) - 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_inc,
    input  logic [addr_width:0]   rd_ptr_gray,
    output logic [addr_width-1:0] w_address,
    output logic [addr_width:0]   w_ptr_gray,
    output logic                  full_flag,
    output logic                  almost_full,
    output logic [addr_width:0]   w_level,
    output logic                  overflow
);

    localparam logic [addr_width:0] c_AF_THRESH = (addr_width+1)'(af_thresh);

    logic [addr_width:0] r_wbin;
    logic [addr_width:0] r_wgray;
    logic [addr_width:0] r_rq1;
    logic [addr_width:0] r_rq2;
    logic                r_full;
    logic                r_almost_full;
    logic                r_overflow;
    logic [addr_width:0] r_level;

    logic                w_accept;
    logic [addr_width:0] w_wbin_nxt;
    logic [addr_width:0] w_wgray_nxt;
    logic [addr_width:0] w_rbin_s;
    logic [addr_width:0] w_level_nxt;
    logic                w_full_nxt;

    // Full is judged on the registered flag so the accept path never loops.
    assign w_accept    = w_inc && !r_full;
    assign w_wbin_nxt  = r_wbin + {{addr_width{1'b0}}, w_accept};
    assign w_wgray_nxt = w_wbin_nxt ^ (w_wbin_nxt >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= addr_width; i++) begin : g_gray2bin
        assign w_rbin_s[i] = ^r_rq2[addr_width:i];
    end

    assign w_level_nxt = w_wbin_nxt - w_rbin_s;
    assign w_full_nxt  = (w_wgray_nxt == {~r_rq2[addr_width:addr_width-1],
                                           r_rq2[addr_width-2:0]});

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= rd_ptr_gray;
            r_rq2 <= r_rq1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_level       <= '0;
        end else begin
            r_wbin        <= w_wbin_nxt;
            r_wgray       <= w_wgray_nxt;
            r_full        <= w_full_nxt;
            r_almost_full <= (w_level_nxt >= c_AF_THRESH);
            r_overflow    <= w_inc && r_full;
            r_level       <= w_level_nxt;
        end
    end

    assign w_address   = r_wbin[addr_width-1:0];
    assign w_ptr_gray  = r_wgray;
    assign full_flag   = r_full;
    assign almost_full = r_almost_full;
    assign w_level     = r_level;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
// ============================================================================
// Module   : tb_fifo_wr_ctrl
// Brief    : Self-checking bench for fifo_wr_ctrl against a counting model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_ctrl;

    localparam int c_AW = 4;
    localparam int c_D  = 16;

    logic            w_clk = 1'b0;
    logic            w_rst_n = 1'b0;
    logic            w_inc = 1'b0;
    logic [c_AW:0]   rd_ptr_gray = '0;
    logic [c_AW-1:0] w_address;
    logic [c_AW:0]   w_ptr_gray;
    logic            full_flag;
    logic            almost_full;
    logic [c_AW:0]   w_level;
    logic            overflow;

    fifo_wr_ctrl #(.addr_width(c_AW), .af_thresh(c_D-2)) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_inc       (w_inc),
        .rd_ptr_gray (rd_ptr_gray),
        .w_address   (w_address),
        .w_ptr_gray  (w_ptr_gray),
        .full_flag   (full_flag),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: counts of accepted writes and of reads, plus the read count
    // seen at each past edge (the write side reacts two edges late).
    int   wcnt = 0;
    int   rd_cnt = 0;
    int   rd_hist[$];
    int   m_level = 0;
    logic m_full = 1'b0;
    logic m_af = 1'b0;
    logic m_ovf = 1'b0;

    function automatic logic [c_AW:0] gray5(input int n);
        logic [c_AW:0] b;
        b = n[c_AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wcnt = 0; rd_cnt = 0; rd_hist.delete();
        m_level = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        w_inc = 1'b0;
        rd_ptr_gray = '0;
        w_rst_n = 1'b0;
        model_reset();
        @(posedge w_clk); #3;
        w_rst_n = 1'b1;
        #1;
    endtask

    // One clock: drive inputs, take the edge, update the model.
    task automatic tick(input logic inc);
        int seen;
        w_inc = inc;
        rd_ptr_gray = gray5(rd_cnt);
        @(posedge w_clk);
        rd_hist.push_back(rd_cnt);
        if (rd_hist.size() > 3) void'(rd_hist.pop_front());
        seen = (rd_hist.size() >= 3) ? rd_hist[rd_hist.size()-3] : 0;
        m_ovf = inc && m_full;
        if (inc && !m_full) wcnt++;
        m_level = wcnt - seen;
        m_full = (m_level == c_D);
        m_af = (m_level >= c_D - 2);
        #1;
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        #12;
        n_tests++; if ({w_address, w_ptr_gray, full_flag, almost_full, w_level, overflow} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b exp all 0",
                w_address, w_ptr_gray, full_flag, almost_full, w_level, overflow); end
        do_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < c_D; i++) begin
            n_tests++; if (w_address !== 4'(i)) begin
                n_fail++; $display("FAIL fill_addr: got %0d exp %0d", w_address, i); end
            tick(1'b1);
        end
        n_tests++; if (full_flag !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got %b exp 1", full_flag); end
        n_tests++; if (w_ptr_gray !== 5'b11000) begin
            n_fail++; $display("FAIL fill_gray: got %b exp 11000", w_ptr_gray); end
        n_tests++; if (w_level !== 5'd16) begin
            n_fail++; $display("FAIL fill_level: got %0d exp 16", w_level); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1);
            n_tests++; if (overflow !== 1'b1 || full_flag !== 1'b1) begin
                n_fail++; $display("FAIL ovf_pulse: got ovf=%b full=%b exp 1/1", overflow, full_flag); end
            n_tests++; if (w_ptr_gray !== 5'b11000 || w_address !== 4'd0) begin
                n_fail++; $display("FAIL ovf_hold: got gray=%b addr=%0d exp 11000/0", w_ptr_gray, w_address); end
        end
        tick(1'b0);
        n_tests++; if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
    endtask

    task automatic test_read_release();
        rd_cnt = 1;
        for (int e = 1; e <= 3; e++) begin
            tick(1'b0);
            n_tests++; if (full_flag !== (e < 3)) begin
                n_fail++; $display("FAIL rel_full_edge%0d: got %b exp %b", e, full_flag, e < 3); end
        end
        n_tests++; if (w_level !== 5'd15) begin
            n_fail++; $display("FAIL rel_level: got %0d exp 15", w_level); end
        n_tests++; if (w_address !== 4'd0) begin
            n_fail++; $display("FAIL rel_addr: got %0d exp 0", w_address); end
        tick(1'b1);
        n_tests++; if (full_flag !== 1'b1 || w_address !== 4'd1) begin
            n_fail++; $display("FAIL rel_refill: got full=%b addr=%0d exp 1/1", full_flag, w_address); end
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 0; i < 13; i++) tick(1'b1);
        n_tests++; if (almost_full !== 1'b0 || w_level !== 5'd13) begin
            n_fail++; $display("FAIL af_below: got af=%b lvl=%0d exp 0/13", almost_full, w_level); end
        tick(1'b1);
        n_tests++; if (almost_full !== 1'b1 || w_level !== 5'd14) begin
            n_fail++; $display("FAIL af_assert: got af=%b lvl=%0d exp 1/14", almost_full, w_level); end
        rd_cnt = 1;
        for (int e = 1; e <= 3; e++) begin
            tick(1'b0);
            n_tests++; if (almost_full !== (e < 3)) begin
                n_fail++; $display("FAIL af_release_edge%0d: got %b exp %b", e, almost_full, e < 3); end
        end
    endtask

    task automatic test_wrap();
        logic [c_AW:0] prev;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rd_cnt = (wcnt >= 2) ? wcnt - 2 : 0;
            prev = w_ptr_gray;
            tick(1'b1);
            n_tests++; if ($countones(prev ^ w_ptr_gray) != 1) begin
                n_fail++; $display("FAIL wrap_gray_step: got %b->%b exp one-bit change", prev, w_ptr_gray); end
            n_tests++; if (full_flag !== 1'b0 || w_level !== m_level[c_AW:0]) begin
                n_fail++; $display("FAIL wrap_status: got full=%b lvl=%0d exp 0/%0d", full_flag, w_level, m_level); end
            if (i == 31) begin
                n_tests++; if (w_ptr_gray !== 5'b00000 || w_address !== 4'd0) begin
                    n_fail++; $display("FAIL wrap_zero: got gray=%b addr=%0d exp 00000/0", w_ptr_gray, w_address); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (rd_cnt < wcnt && $urandom_range(0, 99) < 45) rd_cnt++;
            tick($urandom_range(0, 99) < 60);
            n_tests++; if (w_address !== wcnt[c_AW-1:0] || w_ptr_gray !== gray5(wcnt)) begin
                n_fail++; $display("FAIL rand_ptr cyc%0d: got addr=%0d gray=%b exp %0d/%b",
                    i, w_address, w_ptr_gray, wcnt[c_AW-1:0], gray5(wcnt)); end
            n_tests++; if (full_flag !== m_full || almost_full !== m_af || overflow !== m_ovf
                           || w_level !== m_level[c_AW:0]) begin
                n_fail++; $display("FAIL rand_status cyc%0d: got full=%b af=%b ovf=%b lvl=%0d exp %b/%b/%b/%0d",
                    i, full_flag, almost_full, overflow, w_level, m_full, m_af, m_ovf, m_level); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b1);
        n_tests++; if (w_level !== 5'd9) begin
            n_fail++; $display("FAIL mid_level: got %0d exp 9", w_level); end
        #2;
        w_inc = 1'b0;
        w_rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if ({w_address, w_ptr_gray, full_flag, almost_full, w_level, overflow} !== '0) begin
            n_fail++; $display("FAIL mid_async_clear: got addr=%0d gray=%b lvl=%0d exp all 0",
                w_address, w_ptr_gray, w_level); end
        #2;
        w_rst_n = 1'b1;
        n_tests++; if (w_address !== 4'd0) begin
            n_fail++; $display("FAIL mid_first_addr: got %0d exp 0", w_address); end
        tick(1'b1);
        n_tests++; if (w_level !== 5'd1 || w_address !== 4'd1) begin
            n_fail++; $display("FAIL mid_first_write: got lvl=%0d addr=%0d exp 1/1", w_level, w_address); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_almost_full();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
